spi_frame_scheduler: RTL

- Shares one synchronous frame-buffer read port among CHANNELS icnd2110 SPI channel drivers.
- Sequences refresh frames: pulses frame start to every channel, then serves per-channel byte requests round-robin, one grant per cycle.
- Enforces an inter-frame gap before the next frame.
- Sits between the pixel frame buffer, which is written by the WS2812 input path, and the icnd2110 channel instances in chip.

---
 rtl/spi_frame_scheduler.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/spi_frame_scheduler.sv
// Frame sequencer and round-robin arbiter sharing one frame-buffer
// read port among the icnd2110 SPI channel drivers.
module spi_frame_scheduler #(
  parameter int CHANNELS   = 8,
  parameter int BYTECOUNT  = 72,
  parameter int ADDR_W     = 10,
  parameter int GAP_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [CHANNELS-1:0] ch_req,
  output logic [CHANNELS-1:0] ch_ack,
  output logic [7:0]          ch_data,
  output logic                frame_start,
  output logic                frame_done,
  output logic                mem_rd,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [7:0]          mem_rdata,
  output logic                busy
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int BW = $clog2(BYTECOUNT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, START, SERVE, DRAIN, GAP
  } state_e;

  state_e              state_q, state_d;
  logic [BW-1:0]       idx_q [CHANNELS];
  logic [BW-1:0]       idx_d [CHANNELS];
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic [CW-1:0]       rr_q, rr_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic                rd_q, rd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CW-1:0]       rch_q;
  logic                v2_q;
  logic [CW-1:0]       ch2_q;
  logic [CHANNELS-1:0] ack_q, ack_d;
  logic [7:0]          data_q;

  logic [CHANNELS-1:0] elig;
  logic                all_done;
  logic                gnt_v;
  logic [CW-1:0]       gnt_ch;
  logic                drained;

  always_comb begin
    elig     = '0;
    all_done = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      elig[i] = ch_req[i] & ~pend_q[i]
              & (idx_q[i] < BW'(BYTECOUNT));
      if (idx_q[i] != BW'(BYTECOUNT))
        all_done = 1'b0;
    end
  end

  // First eligible channel at or after rr_q, wrapping.
  always_comb begin
    gnt_v  = 1'b0;
    gnt_ch = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (!gnt_v && elig[(int'(rr_q) + k) % CHANNELS]) begin
        gnt_v  = 1'b1;
        gnt_ch = CW'((int'(rr_q) + k) % CHANNELS);
      end
    end
  end

  assign drained = (pend_q == '0) && !rd_q && !v2_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pend_d     = pend_q & ~ack_q;
    rr_d       = rr_q;
    gap_d      = gap_q;
    rd_d       = 1'b0;
    addr_d     = '0;
    frame_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable)
          state_d = START;
      end
      START: begin
        for (int i = 0; i < CHANNELS; i++)
          idx_d[i] = '0;
        state_d = SERVE;
      end
      SERVE: begin
        if (all_done) begin
          state_d = DRAIN;
        end else if (gnt_v) begin
          rd_d           = 1'b1;
          addr_d         = ADDR_W'(int'(gnt_ch) * BYTECOUNT)
                         + ADDR_W'(idx_q[gnt_ch]);
          pend_d[gnt_ch] = 1'b1;
          idx_d[gnt_ch]  = idx_q[gnt_ch] + 1'b1;
          rr_d = (gnt_ch == CW'(CHANNELS - 1))
               ? '0 : gnt_ch + 1'b1;
        end
      end
      DRAIN: begin
        if (drained) begin
          frame_done = 1'b1;
          gap_d      = '0;
          state_d    = GAP;
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          gap_d   = '0;
          state_d = enable ? START : IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack_d = '0;
    if (v2_q)
      ack_d[ch2_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      for (int i = 0; i < CHANNELS; i++)
        idx_q[i] <= '0;
      pend_q  <= '0;
      rr_q    <= '0;
      gap_q   <= '0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      rch_q   <= '0;
      v2_q    <= 1'b0;
      ch2_q   <= '0;
      ack_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      rr_q    <= rr_d;
      gap_q   <= gap_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      if (rd_d)
        rch_q <= gnt_ch;
      v2_q    <= rd_q;
      ch2_q   <= rch_q;
      ack_q   <= ack_d;
      if (v2_q)
        data_q <= mem_rdata;
    end
  end

  assign ch_ack      = ack_q;
  assign ch_data     = data_q;
  assign frame_start = (state_q == START);
  assign mem_rd      = rd_q;
  assign mem_addr    = addr_q;
  assign busy        = (state_q != IDLE);

endmodule
